// File: rtl/ps2_spacebar_rx_pkg.sv
// Shared scan-code constants and receiver state
// encoding for the PS/2 spacebar receiver.
package ps2_spacebar_rx_pkg;

  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  function automatic logic odd_ok(
    input logic [7:0] b,
    input logic       p
  );
    return ^{b, p};
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronises ps2c/ps2d, de-glitches ps2c and
// emits a one-cycle pulse on each filtered falling edge.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2c,
  input  logic ps2d,
  output logic fall,
  output logic data
);

  logic [1:0]            c_sync;
  logic [1:0]            d_sync;
  logic [FILTER_LEN-1:0] sh;
  logic                  filt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_sync <= '1;
      d_sync <= '1;
      sh     <= '1;
      filt   <= 1'b1;
      fall   <= 1'b0;
    end else begin
      c_sync <= {c_sync[0], ps2c};
      d_sync <= {d_sync[0], ps2d};
      sh     <= {sh[FILTER_LEN-2:0], c_sync[1]};
      fall   <= 1'b0;
      if (&sh) begin
        filt <= 1'b1;
      end else if (~|sh) begin
        filt <= 1'b0;
        fall <= filt;
      end
    end
  end

  // ps2d is stable for the whole low phase, so the
  // plain synchronised value lines up with fall.
  assign data = d_sync[1];

endmodule

// File: rtl/ps2_spacebar_rx.sv
// PS/2 device-to-host deframer with spacebar make/break
// decode, press pulse and LED status bus.
module ps2_spacebar_rx
  import ps2_spacebar_rx_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = CLK_HZ / 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err,
  output logic       spacebar_pressed,
  output logic       spacebar_pulse,
  output logic [7:0] led
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_MAX =
    TW'(TIMEOUT_CYC - 1);

  logic            fall;
  logic            d;
  rx_state_t       state;
  logic [2:0]      bit_cnt;
  logic [7:0]      sr;
  logic            par;
  logic [TW-1:0]   to_cnt;
  logic            brk;
  logic            ext;
  logic            led7;

  ps2_clk_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .ps2c  (ps2c),
    .ps2d  (ps2d),
    .fall  (fall),
    .data  (d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      sr         <= '0;
      par        <= 1'b0;
      to_cnt     <= '0;
      scan_code  <= '0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state == IDLE || fall)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + 1'b1;

      if (state != IDLE && !fall &&
          to_cnt == TO_MAX) begin
        state     <= IDLE;
        frame_err <= 1'b1;
      end else if (fall) begin
        unique case (state)
          IDLE: begin
            if (!d) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            sr      <= {d, sr[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7)
              state <= PARITY;
          end
          PARITY: begin
            par   <= d;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (d && odd_ok(sr, par)) begin
              scan_code  <= sr;
              code_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Prefix flags persist until a non-prefix code
  // or a bad frame consumes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brk              <= 1'b0;
      ext              <= 1'b0;
      spacebar_pressed <= 1'b0;
      spacebar_pulse   <= 1'b0;
      led7             <= 1'b0;
    end else begin
      spacebar_pulse <= 1'b0;
      if (frame_err) begin
        brk <= 1'b0;
        ext <= 1'b0;
      end else if (code_valid) begin
        unique case (1'b1)
          (scan_code == SC_BREAK): brk <= 1'b1;
          (scan_code == SC_EXT):   ext <= 1'b1;
          default: begin
            if (scan_code == SC_SPACE && !ext) begin
              spacebar_pressed <= ~brk;
              if (!brk && !spacebar_pressed) begin
                spacebar_pulse <= 1'b1;
                led7           <= ~led7;
              end
            end
            brk <= 1'b0;
            ext <= 1'b0;
          end
        endcase
      end
    end
  end

  assign led = {led7, scan_code[6:0]};

endmodule
